// File: rtl/series_job_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : series_job_sequencer_if
// Brief    : Operand stream, engine handshake and result stream bundle.
// Revision : 1.0 - initial release
//============================================================================
interface series_job_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;

    logic             eng_start;
    logic             eng_ready;
    logic [WIDTH-1:0] eng_x;
    logic [WIDTH-1:0] eng_y;
    logic [WIDTH-1:0] eng_result;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    // slave: the sequencer itself; master: host plus engine around it
    modport slave (
        input  in_valid, in_x, in_y, eng_ready, eng_result, out_ready,
        output in_ready, eng_start, eng_x, eng_y, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_x, in_y, eng_ready, eng_result, out_ready,
        input  in_ready, eng_start, eng_x, eng_y, out_valid, out_data, out_err
    );
endinterface
`default_nettype wire

// File: rtl/series_job_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : series_job_sequencer
// Brief    : Feeds one operand pair per job to the series engine, returns
//            the result and flags jobs that never complete.
// Revision : 1.0 - initial release
//============================================================================
module series_job_sequencer #(
    parameter int WIDTH        = 16,
    parameter int START_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    series_job_sequencer_if.slave  bus,
    output logic                   busy,
    output logic [7:0]             jobs_done
);

    localparam int c_WD_W = ((TIMEOUT + 1) > 256) ? $clog2(TIMEOUT + 1) : 8;
    localparam int c_SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_SC_W-1:0] c_SC_RELOAD = c_SC_W'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_RDY  = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_OUT       = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_eng_start;
    logic [WIDTH-1:0]   r_eng_x;
    logic [WIDTH-1:0]   r_eng_y;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_err;
    logic [7:0]         r_jobs_done;
    logic [c_WD_W-1:0]  r_wd;
    logic [c_SC_W-1:0]  r_sc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_eng_start <= 1'b0;
            r_eng_x     <= '0;
            r_eng_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_jobs_done <= 8'd0;
            r_wd        <= '0;
            r_sc        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_eng_x <= bus.in_x;
                        r_eng_y <= bus.in_y;
                        r_state <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (bus.eng_ready) begin
                        r_eng_start <= 1'b1;
                        r_sc        <= c_SC_RELOAD;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (r_sc == '0) begin
                        r_eng_start <= 1'b0;
                        r_wd        <= '0;
                        r_state     <= S_WAIT_BUSY;
                    end else begin
                        r_sc <= r_sc - 1'b1;
                    end
                end
                // eng_ready may still be high here: the engine has not seen start yet
                S_WAIT_BUSY: begin
                    r_wd <= r_wd + 1'b1;
                    if (r_wd == c_WD_LAST) begin
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else if (!bus.eng_ready) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    r_wd <= r_wd + 1'b1;
                    if (bus.eng_ready) begin
                        r_out_data  <= bus.eng_result;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else if (r_wd == c_WD_LAST) begin
                        r_out_data  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_jobs_done <= r_jobs_done + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_eng_start <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.eng_start = r_eng_start;
    assign bus.eng_x     = r_eng_x;
    assign bus.eng_y     = r_eng_y;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_err   = r_out_err;
    assign busy          = (r_state != S_IDLE);
    assign jobs_done     = r_jobs_done;

endmodule
`default_nettype wire

// File: doc/series_job_sequencer.md
# series_job_sequencer

Host-side initiator for the iterative series-evaluation datapath/controller pair. Accepts one operand pair per job over a valid/ready stream and drives the engine's start/ready handshake. Holds the operands stable for the whole job, captures the engine result and returns it over a valid/ready result stream. A watchdog flags jobs that never complete.

## Interface
Parameters:
- WIDTH, 16, operand and result width
- START_CYCLES, 1, cycles `eng_start` is held high per job (≥1)
- TIMEOUT, 255, maximum cycles from `eng_start` release to `eng_ready` return (≥4)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  sequencer accepts operands (combinational, =1 only in IDLE)
- in_x  in  WIDTH  operand x
- in_y  in  WIDTH  operand y
- eng_start  out  1  start request to engine controller (registered)
- eng_ready  in  1  engine idle indication; high only while the engine is idle
- eng_x  out  WIDTH  operand x to datapath (registered, stable for the whole job)
- eng_y  out  WIDTH  operand y to datapath (registered, stable for the whole job)
- eng_result  in  WIDTH  engine result register; valid while `eng_ready` is high after a job
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  captured result
- out_err  out  1  job ended by timeout; `out_data`=0
- busy  out  1  high in every state except IDLE
- jobs_done  out  8  count of completed result handshakes; wraps 255→0

## Operation
FSM states: IDLE, WAIT_RDY, START, WAIT_BUSY, WAIT_DONE, OUT.
- IDLE: `in_ready`=1. On `in_valid`: latch `in_x`/`in_y` into `eng_x`/`eng_y`, go to WAIT_RDY.
- WAIT_RDY: wait for `eng_ready`=1, then go to START. No timeout applies here.
- START: `eng_start`=1 for exactly START_CYCLES cycles, then go to WAIT_BUSY with `eng_start`=0. The engine sits in its init state while start is high, so the hold time only delays the job.
- WAIT_BUSY: on `eng_ready`=0, go to WAIT_DONE.
- WAIT_DONE: on `eng_ready`=1, capture `eng_result` into `out_data`, set `out_err`=0, go to OUT.
- OUT: `out_valid`=1. On `out_ready`: `jobs_done`+1, `out_valid`=0, go to IDLE. `out_data`/`out_err` are held until the next capture.
- Watchdog: an 8+ bit counter clears on START exit and increments in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT in either state: `out_data`=0, `out_err`=1, go to OUT. The engine is not reset by the sequencer.
- `eng_x`/`eng_y` change only on IDLE acceptance.
- Reset (async, any state): state=IDLE, `eng_start`=0, `out_valid`=0, `out_data`=0, `out_err`=0, `eng_x`=`eng_y`=0, `jobs_done`=0, watchdog=0. Hence `in_ready`=1 and `busy`=0 during and after reset. A reset mid-job abandons the job with no result produced.

## Timing
- Cycle 0: accept in IDLE. Cycle 1: WAIT_RDY (`eng_ready`=1). Cycles 2..1+START_CYCLES: `eng_start`=1. Next cycle: WAIT_BUSY.
- With an idle engine, `eng_ready` falls the cycle after start is first sampled, so WAIT_BUSY lasts one cycle.
- Result capture happens on the edge where WAIT_DONE samples `eng_ready`=1. `out_valid` rises the following cycle.
- Input-to-output latency = 4 + START_CYCLES + engine busy cycles.
- `in_ready` and `out_valid` are never high in the same cycle, so a new job cannot start before the previous result is consumed.
- `eng_ready` high on entry to WAIT_BUSY (engine has not yet reacted) is not treated as completion.

## Test plan
- Single job, behavioural engine busy 12 cycles returning 0x1234, `out_ready`=1 → `out_data`=0x1234, `out_err`=0; `out_valid` 17 cycles after acceptance; `jobs_done`=1.
- START_CYCLES=3 → `eng_start` high exactly 3 cycles; `eng_x`/`eng_y` unchanged until `out_valid`; `in_ready`=0 throughout.
- `eng_ready` held low at acceptance for 5 cycles → `eng_start` is asserted only after `eng_ready` rises; no watchdog error.
- Engine never returns ready, TIMEOUT=20 → `out_err`=1, `out_data`=0 exactly 20 cycles after START exit; the next job still runs normally.
- `out_ready` held low 10 cycles → `out_valid` and `out_data` stable; `in_valid` ignored; 256 jobs → `jobs_done` wraps to 0.
- `rst_n` low during WAIT_DONE → `eng_start`/`out_valid`/`busy` go to 0 immediately, `in_ready`=1, `jobs_done`=0.
